cache_flush_walker: RTL and testbench



---
 rtl/cache_flush_walker.sv | 131 +++++++++++++
 tb/tb_cache_flush_walker.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cache_flush_walker.sv
// Per-bank flush sequencer: walks every (line, way) slot, throttled by retired ops and
// writeback acks, and returns one completion once everything has drained.
module cache_flush_walker #(
    parameter int CACHE_SIZE  = 1024,
    parameter int LINE_SIZE   = 16,
    parameter int NUM_BANKS   = 1,
    parameter int NUM_WAYS    = 1,
    parameter int BANK_ID     = 0,
    parameter int MAX_PENDING = 4,
    localparam int LINES      = CACHE_SIZE / (LINE_SIZE * NUM_WAYS * NUM_BANKS),
    localparam int LSEL_W     = (LINES > 1) ? $clog2(LINES) : 1,
    localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_req_valid,
    output logic                flush_req_ready,
    output logic                flush_rsp_valid,
    input  logic                flush_rsp_ready,
    output logic                flush_valid,
    input  logic                flush_ready,
    output logic [LSEL_W-1:0]   flush_line_sel,
    output logic [NUM_WAYS-1:0] flush_way_sel,
    input  logic                done_valid,
    input  logic                done_dirty,
    input  logic                wb_ack,
    output logic                busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WALK  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]          state_reg, state_next;
    logic [LSEL_W-1:0]   line_reg, line_next;
    logic [NUM_WAYS-1:0] way_reg, way_next, way_rot;
    logic [CNT_W-1:0]    outstanding_reg, outstanding_next;
    logic [CNT_W+1:0]    cnt_up, cnt_dn;
    logic                op_hs, last_slot;

    generate
        if (NUM_WAYS == 1) begin : g_one_way
            assign way_rot = way_reg;
        end else begin : g_multi_way
            assign way_rot = {way_reg[NUM_WAYS-2:0], way_reg[NUM_WAYS-1]};
        end
    endgenerate

    // flush_valid is a decode of registered state only; flush_ready never feeds back into it
    assign flush_valid     = (state_reg == WALK) && (outstanding_reg < CNT_W'(MAX_PENDING));
    assign flush_req_ready = (state_reg == IDLE);
    assign flush_rsp_valid = (state_reg == RESP);
    assign busy            = (state_reg != IDLE);
    assign flush_line_sel  = line_reg;
    assign flush_way_sel   = flush_valid ? way_reg : '0;

    assign op_hs     = flush_valid && flush_ready;
    assign last_slot = (line_reg == LSEL_W'(LINES - 1)) && way_reg[NUM_WAYS-1];

    // A dirty op stays counted until its writeback ack, a clean one until its done pulse
    assign cnt_up = {2'b00, outstanding_reg} + (CNT_W+2)'(op_hs);
    assign cnt_dn = (CNT_W+2)'(done_valid && !done_dirty) + (CNT_W+2)'(wb_ack);
    assign outstanding_next = CNT_W'(cnt_up - cnt_dn);

    always_comb begin
        state_next = state_reg;
        line_next  = line_reg;
        way_next   = way_reg;
        case (state_reg)
            IDLE: begin
                if (flush_req_valid) begin
                    state_next = WALK;
                    line_next  = '0;
                    way_next   = NUM_WAYS'(1);
                end
            end
            WALK: begin
                if (op_hs) begin
                    way_next = way_rot;
                    if (way_reg[NUM_WAYS-1]) begin
                        line_next = line_reg + LSEL_W'(1);
                    end
                    if (last_slot) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (outstanding_reg == '0) begin
                    state_next = RESP;
                end
            end
            default: begin
                if (flush_rsp_ready) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            line_reg        <= '0;
            way_reg         <= '0;
            outstanding_reg <= '0;
        end else begin
            state_reg       <= state_next;
            line_reg        <= line_next;
            way_reg         <= way_next;
            outstanding_reg <= outstanding_next;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (outstanding_reg <= CNT_W'(MAX_PENDING))
                else $error("bank %0d: outstanding above limit", BANK_ID);
            assert (cnt_up >= cnt_dn)
                else $error("bank %0d: outstanding underflow", BANK_ID);
            assert (!((state_reg == IDLE) && (done_valid || wb_ack)))
                else $error("bank %0d: retire while idle", BANK_ID);
            assert ($onehot0(flush_way_sel))
                else $error("bank %0d: way select not one-hot", BANK_ID);
        end
    end
`endif

endmodule

// File: tb/tb_cache_flush_walker.sv
// Randomized bench: a bank/memory responder plus a slot-count reference model of the walker.
module tb_cache_flush_walker;

    localparam int CACHE_SIZE  = 1024;
    localparam int LINE_SIZE   = 16;
    localparam int NUM_BANKS   = 1;
    localparam int NUM_WAYS    = 2;
    localparam int MAX_PENDING = 4;
    localparam int LINES       = CACHE_SIZE / (LINE_SIZE * NUM_WAYS * NUM_BANKS);
    localparam int OPS         = LINES * NUM_WAYS;
    localparam int LSEL_W      = $clog2(LINES);

    logic                clk = 1'b0;
    logic                reset;
    logic                flush_req_valid, flush_req_ready;
    logic                flush_rsp_valid, flush_rsp_ready;
    logic                flush_valid, flush_ready;
    logic [LSEL_W-1:0]   flush_line_sel;
    logic [NUM_WAYS-1:0] flush_way_sel;
    logic                done_valid, done_dirty, wb_ack, busy;

    cache_flush_walker #(
        .CACHE_SIZE(CACHE_SIZE), .LINE_SIZE(LINE_SIZE), .NUM_BANKS(NUM_BANKS),
        .NUM_WAYS(NUM_WAYS), .BANK_ID(0), .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk(clk), .reset(reset),
        .flush_req_valid(flush_req_valid), .flush_req_ready(flush_req_ready),
        .flush_rsp_valid(flush_rsp_valid), .flush_rsp_ready(flush_rsp_ready),
        .flush_valid(flush_valid), .flush_ready(flush_ready),
        .flush_line_sel(flush_line_sel), .flush_way_sel(flush_way_sel),
        .done_valid(done_valid), .done_dirty(done_dirty), .wb_ack(wb_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: phase 0 idle, 1 walking, 2 draining, 3 responding
    int m_phase  = 0;
    int m_issued = 0;
    int m_outst  = 0;
    int cyc      = 0;
    int last_due = 0;
    int done_due[$];
    bit done_dq[$];
    int wb_due[$];

    task automatic run_flush(input int ready_mode, input int dirty_pct, input int done_max,
                             input int wb_min, input int wb_max, input int rsp_hold,
                             input int reset_at);
        bit finished = 0, did_reset = 0, just_reset = 0, exp_valid, hs;
        int n = 0, rsp_cnt = 0, due;
        while (!finished && n < 4000) begin
            @(negedge clk);
            exp_valid = (m_phase == 1) && (m_outst < MAX_PENDING);
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("req_ready", 32'(flush_req_ready), 32'(m_phase == 0));
            check("rsp_valid", 32'(flush_rsp_valid), 32'(m_phase == 3));
            check("flush_valid", 32'(flush_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("line", 32'(flush_line_sel), 32'(m_issued / NUM_WAYS));
                check("way", 32'(flush_way_sel), 32'(1 << (m_issued % NUM_WAYS)));
            end else begin
                check("way_idle", 32'(flush_way_sel), 32'd0);
            end
            if (just_reset) check("line_rst", 32'(flush_line_sel), 32'd0);
            just_reset = 0;
            reset = 1'b0; done_valid = 1'b0; done_dirty = 1'b0; wb_ack = 1'b0;

            if (reset_at > 0 && !did_reset && m_phase == 1 && m_issued == reset_at) begin
                reset = 1'b1; flush_req_valid = 1'b0; flush_ready = 1'b0; flush_rsp_ready = 1'b0;
                did_reset = 1; just_reset = 1;
                m_phase = 0; m_outst = 0; last_due = 0;
                done_due.delete(); done_dq.delete(); wb_due.delete();
            end else begin
                case (m_phase)
                    0:       flush_req_valid = ($urandom_range(0, 2) == 0);
                    3:       flush_req_valid = 1'b0;
                    default: flush_req_valid = 1'($urandom_range(0, 1));
                endcase
                case (ready_mode)
                    0:       flush_ready = 1'b1;
                    1:       flush_ready = 1'(cyc % 2);
                    default: flush_ready = ($urandom_range(0, 3) != 0);
                endcase
                if (wb_due.size() > 0 && wb_due[0] <= cyc) begin
                    wb_ack = 1'b1;
                    void'(wb_due.pop_front());
                end
                if (done_due.size() > 0 && done_due[0] <= cyc) begin
                    done_valid = 1'b1;
                    done_dirty = done_dq.pop_front();
                    void'(done_due.pop_front());
                    if (done_dirty) wb_due.push_back(cyc + 1 + int'($urandom_range(wb_min, wb_max)));
                end
                if (m_phase == 3) begin
                    flush_rsp_ready = (rsp_cnt >= rsp_hold);
                    rsp_cnt++;
                end else begin
                    flush_rsp_ready = 1'($urandom_range(0, 1));
                end

                hs = exp_valid && flush_ready;
                case (m_phase)
                    0: if (flush_req_valid) begin m_phase = 1; m_issued = 0; end
                    1: if (hs) begin
                        due = cyc + 1 + int'($urandom_range(0, done_max));
                        if (due < last_due) due = last_due;
                        last_due = due;
                        done_due.push_back(due);
                        done_dq.push_back(int'($urandom_range(0, 99)) < dirty_pct);
                        m_issued++;
                        if (m_issued == OPS) m_phase = 2;
                    end
                    2: if (m_outst == 0) m_phase = 3;
                    default: if (flush_rsp_ready) begin m_phase = 0; finished = 1; end
                endcase
                m_outst = m_outst + int'(hs) - int'(done_valid && !done_dirty) - int'(wb_ack);
            end
            cyc++;
            n++;
        end
        check("completed", 32'(finished), 32'd1);
        $display("flush run mode=%0d dirty=%0d reset_at=%0d cycles=%0d finished=%0d",
                 ready_mode, dirty_pct, reset_at, n, finished);
    endtask

    initial begin
        reset = 1'b1; flush_req_valid = 1'b0; flush_rsp_ready = 1'b0; flush_ready = 1'b0;
        done_valid = 1'b0; done_dirty = 1'b0; wb_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(flush_req_ready), 32'd1);
        check("rst_rsp_valid", 32'(flush_rsp_valid), 32'd0);
        check("rst_flush_valid", 32'(flush_valid), 32'd0);
        check("rst_line", 32'(flush_line_sel), 32'd0);
        check("rst_way", 32'(flush_way_sel), 32'd0);
        reset = 1'b0;

        run_flush(0, 0,   0, 0,  0,  0, 0);   // clean walk, full rate
        run_flush(1, 0,   2, 0,  0,  1, 0);   // flush_ready toggling
        run_flush(0, 100, 0, 8,  12, 0, 0);   // all dirty, throttled on wb_ack
        run_flush(0, 30,  1, 20, 20, 5, 0);   // late writebacks drain, response held
        run_flush(2, 50,  2, 0,  4,  2, 10);  // reset at op 10, then restart
        for (int i = 0; i < 5; i++) begin
            run_flush(2, int'($urandom_range(0, 100)), int'($urandom_range(0, 3)), 0,
                      int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
